// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: UART transmitter driven from one MMIO command word.
// Software queues a byte by flipping the request toggle in mmioCommand[8];
// the block echoes that toggle in mmioStatus[0] once the request is taken.
// Bytes are buffered in a small FIFO and sent as 8N1 frames, LSB first.
module mmio_uart_tx #(
    parameter int CLOCKS_PER_BIT  = 434,  // clock cycles per serial bit, >= 2
    parameter int FIFO_DEPTH_LOG2 = 2     // FIFO holds 2**FIFO_DEPTH_LOG2 bytes, >= 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mmioCommand,
    output logic [31:0] mmioStatus,
    output logic        txd
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
    localparam int BAUD_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Command word fields
    logic [7:0] cmd_data;
    logic       cmd_toggle;
    logic       cmd_ovf_clear;
    logic [21:0] unused_cmd_bits;

    assign cmd_data        = mmioCommand[7:0];
    assign cmd_toggle      = mmioCommand[8];
    assign cmd_ovf_clear   = mmioCommand[9];
    assign unused_cmd_bits = mmioCommand[31:10];

    // Request handshake and sticky overflow
    logic ack_reg;
    logic overflow_reg;
    logic req_pending;

    // FIFO storage and bookkeeping
    logic [7:0]                 fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]           count_reg;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic [7:0]                 fifo_head;

    // Transmit shifter
    tx_state_t         state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              txd_reg, txd_next;

    assign fifo_full   = (count_reg == COUNT_FULL);
    assign fifo_empty  = (count_reg == '0);
    assign fifo_head   = fifo_mem[rd_ptr_reg];

    // A request is any mismatch between the software toggle and our echo.
    // Fullness is judged before a same-cycle pop, so a full FIFO drops the
    // byte even if the shifter is about to free a slot.
    assign req_pending = (cmd_toggle != ack_reg);
    assign push        = req_pending && !fifo_full;

    // Echo the toggle; reset adopts the current toggle so no request is invented
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_reg <= cmd_toggle;
        end else if (req_pending) begin
            ack_reg <= cmd_toggle;
        end
    end

    // Sticky overflow flag; a clear wins over a same-cycle dropped request
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (cmd_ovf_clear) begin
            overflow_reg <= 1'b0;
        end else if (req_pending && fifo_full) begin
            overflow_reg <= 1'b1;
        end
    end

    // FIFO data array; pointer reset makes stale contents unreachable
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + FIFO_DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Transmit FSM next state; txd_next is the line level for the next cycle
    // so the output comes straight from a flop
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        txd_next   = 1'b1;
        pop        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    baud_next  = BAUD_RELOAD;
                    bit_next   = 3'd0;
                    state_next = ST_START;
                    txd_next   = 1'b0;
                end
            end

            ST_START: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_RELOAD;
                    state_next = ST_DATA;
                    txd_next   = shift_reg[0];
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                    txd_next  = 1'b0;
                end
            end

            ST_DATA: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_RELOAD;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = ST_STOP;
                        txd_next   = 1'b1;
                    end else begin
                        txd_next = shift_reg[1];
                    end
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                    txd_next  = shift_reg[0];
                end
            end

            ST_STOP: begin
                txd_next = 1'b1;
                if (baud_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    // Transmit FSM registers; reset aborts any frame and parks the line high
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            baud_reg  <= '0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            txd_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
        end
    end

    assign txd = txd_reg;

    // Status word assembly; unused bits read as zero
    always_comb begin
        mmioStatus              = '0;
        mmioStatus[0]           = ack_reg;
        mmioStatus[1]           = fifo_full;
        mmioStatus[2]           = fifo_empty;
        mmioStatus[3]           = (state_reg == ST_IDLE) && fifo_empty;
        mmioStatus[4]           = overflow_reg;
        mmioStatus[8 +: CNT_W]  = count_reg;
    end

endmodule
